// File: rtl/decd_stage.sv
// ---------------------------------------------------------------------------
// decd_stage
//
// Registered MIPS instruction-decode stage. Fetch offers a 32-bit instruction
// and its PC over a valid/ready handshake. The stage holds it in a small
// elastic buffer and presents the decoded fields of the head entry to the ID
// stage. This replaces the old purely combinational field splitter, so there
// is no combinational path from the fetch side to the decode outputs.
//
// Parameters
//   XLEN  width of the extended immediates (>= 32)
//   PC_W  PC width (>= 32)
//   SKID  1: two-entry skid buffer, in_ready comes straight from a register
//         0: single entry, in_ready = ~main_valid | out_ready
//
// Ports
//   clk, rstn      rising-edge clock, asynchronous active-low reset
//   in_valid       fetch offers an instruction
//   in_ready       stage can accept this cycle
//   in_instr       instruction word
//   in_pc          PC of the offered instruction
//   flush          discard all held entries and the incoming one
//   out_valid      decoded head entry present
//   out_ready      consumer takes the head entry
//   out_pc         PC of the head entry
//   op_code..func  R/I-type fields of the head instruction
//   imm16, imm26   raw immediate fields
//   imm_sext       imm16 sign-extended to XLEN
//   imm_zext       imm16 zero-extended to XLEN
//   imm_lui        {imm16, 16'b0} zero-extended to XLEN
//   jump_target    {(out_pc+4)[PC_W-1:28], imm26, 2'b00}
//   is_rtype       op_code == 0
// ---------------------------------------------------------------------------
module decd_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,

    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,

    output logic [5:0]      op_code,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      func,
    output logic [15:0]     imm16,
    output logic [25:0]     imm26,
    output logic [XLEN-1:0] imm_sext,
    output logic [XLEN-1:0] imm_zext,
    output logic [XLEN-1:0] imm_lui,
    output logic [PC_W-1:0] jump_target,
    output logic            is_rtype
);

    // -----------------------------------------------------------------------
    // Head (main) entry. All decode outputs are derived from this entry only.
    // -----------------------------------------------------------------------
    logic            main_valid;
    logic [31:0]     main_instr;
    logic [PC_W-1:0] main_pc;

    logic            push;
    logic            pop;

    // A flushed cycle never accepts the input, even if in_ready is high.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = main_valid & out_ready;

    generate
        if (SKID) begin : g_skid
            // ---------------------------------------------------------------
            // Two-entry skid buffer. in_ready depends only on skid_valid, so
            // the upstream ready path is a single flop. When the consumer
            // stalls, the instruction already in flight lands in the skid.
            // ---------------------------------------------------------------
            logic            skid_valid;
            logic [31:0]     skid_instr;
            logic [PC_W-1:0] skid_pc;

            assign in_ready = ~skid_valid;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    main_valid <= 1'b0;
                    main_instr <= '0;
                    main_pc    <= '0;
                    skid_valid <= 1'b0;
                    skid_instr <= '0;
                    skid_pc    <= '0;
                end else if (flush) begin
                    // Data registers keep their contents; only validity drops.
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else if (skid_valid) begin
                    // in_ready is low here, so no push can arrive. A pop
                    // promotes the skid entry; main stays valid.
                    if (pop) begin
                        main_instr <= skid_instr;
                        main_pc    <= skid_pc;
                        skid_valid <= 1'b0;
                    end
                end else if (push) begin
                    if (!main_valid || pop) begin
                        main_instr <= in_instr;
                        main_pc    <= in_pc;
                        main_valid <= 1'b1;
                    end else begin
                        skid_instr <= in_instr;
                        skid_pc    <= in_pc;
                        skid_valid <= 1'b1;
                    end
                end else if (pop) begin
                    main_valid <= 1'b0;
                end
            end
        end else begin : g_single
            // ---------------------------------------------------------------
            // Single entry. The slot can be refilled in the cycle it is being
            // consumed, which makes in_ready combinational on out_ready.
            // ---------------------------------------------------------------
            assign in_ready = ~main_valid | out_ready;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    main_valid <= 1'b0;
                    main_instr <= '0;
                    main_pc    <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (push) begin
                    main_instr <= in_instr;
                    main_pc    <= in_pc;
                    main_valid <= 1'b1;
                end else if (pop) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Field decode of the head entry.
    // -----------------------------------------------------------------------
    assign out_valid = main_valid;
    assign out_pc    = main_pc;

    assign op_code = main_instr[31:26];
    assign rs      = main_instr[25:21];
    assign rt      = main_instr[20:16];
    assign rd      = main_instr[15:11];
    assign shamt   = main_instr[10:6];
    assign func    = main_instr[5:0];
    assign imm16   = main_instr[15:0];
    assign imm26   = main_instr[25:0];

    assign is_rtype = (op_code == 6'd0);

    assign imm_sext = {{(XLEN-16){imm16[15]}}, imm16};
    assign imm_zext = {{(XLEN-16){1'b0}}, imm16};
    assign imm_lui  = XLEN'({imm16, 16'h0000});

    // -----------------------------------------------------------------------
    // Jump target. Only bits PC_W-1:28 of pc+4 are needed; adding 4 carries
    // into bit 28 exactly when bits 27:2 are all ones. The upper add wraps
    // naturally, giving pc+4 mod 2^PC_W.
    // -----------------------------------------------------------------------
    logic [PC_W-1:28] pc_next_hi;

    assign pc_next_hi  = main_pc[PC_W-1:28] + (PC_W-28)'(&main_pc[27:2]);
    assign jump_target = {pc_next_hi, imm26, 2'b00};

endmodule

// File: tb/tb_decd_stage.sv
// ---------------------------------------------------------------------------
// tb_decd_stage
//
// Self-checking bench for decd_stage. Two instances share clock and reset:
// u_skid (SKID=1) and u_flow (SKID=0). Each accepted instruction is pushed
// into a per-instance scoreboard queue; every consumed head entry is popped
// and its decoded fields are compared against an independent decode model.
// Directed checks cover reset values, latency, backpressure, flush and
// asynchronous reset.
// ---------------------------------------------------------------------------
module tb_decd_stage;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    int checks   = 0;
    int failures = 0;

    entry_t s_q[$];
    entry_t f_q[$];

    // Skid-buffer instance signals
    logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
    logic [31:0] s_in_instr, s_in_pc, s_out_pc;
    logic [5:0]  s_op_code, s_func;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [15:0] s_imm16;
    logic [25:0] s_imm26;
    logic [31:0] s_imm_sext, s_imm_zext, s_imm_lui, s_jump_target;
    logic        s_is_rtype;
    logic [255:0] s_obs;

    // Single-entry instance signals
    logic        f_in_valid, f_in_ready, f_flush, f_out_valid, f_out_ready;
    logic [31:0] f_in_instr, f_in_pc, f_out_pc;
    logic [5:0]  f_op_code, f_func;
    logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
    logic [15:0] f_imm16;
    logic [25:0] f_imm26;
    logic [31:0] f_imm_sext, f_imm_zext, f_imm_lui, f_jump_target;
    logic        f_is_rtype;
    logic [255:0] f_obs;

    decd_stage #(.XLEN(32), .PC_W(32), .SKID(1'b1)) u_skid (
        .clk(clk), .rstn(rstn),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_instr(s_in_instr), .in_pc(s_in_pc),
        .flush(s_flush),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pc(s_out_pc),
        .op_code(s_op_code), .rs(s_rs), .rt(s_rt), .rd(s_rd),
        .shamt(s_shamt), .func(s_func), .imm16(s_imm16), .imm26(s_imm26),
        .imm_sext(s_imm_sext), .imm_zext(s_imm_zext), .imm_lui(s_imm_lui),
        .jump_target(s_jump_target), .is_rtype(s_is_rtype)
    );

    decd_stage #(.XLEN(32), .PC_W(32), .SKID(1'b0)) u_flow (
        .clk(clk), .rstn(rstn),
        .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_instr(f_in_instr), .in_pc(f_in_pc),
        .flush(f_flush),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_pc(f_out_pc),
        .op_code(f_op_code), .rs(f_rs), .rt(f_rt), .rd(f_rd),
        .shamt(f_shamt), .func(f_func), .imm16(f_imm16), .imm26(f_imm26),
        .imm_sext(f_imm_sext), .imm_zext(f_imm_zext), .imm_lui(f_imm_lui),
        .jump_target(f_jump_target), .is_rtype(f_is_rtype)
    );

    assign s_obs = {21'd0, s_out_pc, s_op_code, s_rs, s_rt, s_rd, s_shamt, s_func,
                    s_imm16, s_imm26, s_imm_sext, s_imm_zext, s_imm_lui,
                    s_jump_target, s_is_rtype};
    assign f_obs = {21'd0, f_out_pc, f_op_code, f_rs, f_rt, f_rd, f_shamt, f_func,
                    f_imm16, f_imm26, f_imm_sext, f_imm_zext, f_imm_lui,
                    f_jump_target, f_is_rtype};

    // Expected decode bundle, same field order as s_obs/f_obs.
    function automatic logic [255:0] model(input logic [31:0] i, input logic [31:0] pc);
        logic [31:0] next_pc, sext, zext, lui, target;
        next_pc = pc + 32'd4;
        sext    = {{16{i[15]}}, i[15:0]};
        zext    = {16'h0000, i[15:0]};
        lui     = {i[15:0], 16'h0000};
        target  = {next_pc[31:28], i[25:0], 2'b00};
        return {21'd0, pc, i[31:26], i[25:21], i[20:16], i[15:11], i[10:6], i[5:0],
                i[15:0], i[25:0], sext, zext, lui, target, (i[31:26] == 6'd0)};
    endfunction

    task automatic check_output(input string tag, input logic [255:0] observed,
                                input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        check_output(tag, {224'd0, observed}, {224'd0, expected});
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] instr,
                                  input logic [31:0] pc, input logic ready,
                                  input logic fl);
        s_in_valid  = valid;
        s_in_instr  = instr;
        s_in_pc     = pc;
        s_out_ready = ready;
        s_flush     = fl;
    endtask

    task automatic apply_flow(input logic valid, input logic [31:0] instr,
                              input logic [31:0] pc, input logic ready,
                              input logic fl);
        f_in_valid  = valid;
        f_in_instr  = instr;
        f_in_pc     = pc;
        f_out_ready = ready;
        f_flush     = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the skid instance, sampled mid-cycle.
    always @(negedge clk) begin
        entry_t e;
        if (!rstn) begin
            s_q.delete();
        end else begin
            if (s_out_valid && s_out_ready) begin
                check_output("skid_pop_has_entry", 256'(s_q.size() != 0), 256'd1);
                if (s_q.size() != 0) begin
                    e = s_q.pop_front();
                    check_output("skid_head", s_obs, model(e.instr, e.pc));
                end
            end
            if (s_flush) begin
                s_q.delete();
            end else if (s_in_valid && s_in_ready) begin
                e.instr = s_in_instr;
                e.pc    = s_in_pc;
                s_q.push_back(e);
            end
        end
    end

    // Scoreboard for the single-entry instance.
    always @(negedge clk) begin
        entry_t e;
        if (!rstn) begin
            f_q.delete();
        end else begin
            if (f_out_valid && f_out_ready) begin
                check_output("flow_pop_has_entry", 256'(f_q.size() != 0), 256'd1);
                if (f_q.size() != 0) begin
                    e = f_q.pop_front();
                    check_output("flow_head", f_obs, model(e.instr, e.pc));
                end
            end
            if (f_flush) begin
                f_q.delete();
            end else if (f_in_valid && f_in_ready) begin
                e.instr = f_in_instr;
                e.pc    = f_in_pc;
                f_q.push_back(e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of sequence");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        apply_flow(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2;

        // Reset state
        check_word("rst_out_valid", 32'(s_out_valid), 32'd0);
        check_word("rst_in_ready", 32'(s_in_ready), 32'd1);
        check_word("rst_is_rtype", 32'(s_is_rtype), 32'd1);
        check_word("rst_jump_target", s_jump_target, 32'h0000_0000);
        check_output("rst_decode", s_obs, model(32'h0, 32'h0));
        check_word("rst_flow_in_ready", 32'(f_in_ready), 32'd1);
        check_word("rst_flow_out_valid", 32'(f_out_valid), 32'd0);

        #9 rstn = 1'b1;
        next_cycle();

        // Basic decode, one instruction per cycle
        apply_stimulus(1'b1, 32'h8D2A_0004, 32'h0000_3000, 1'b1, 1'b0);
        next_cycle();
        check_word("lw_out_valid", 32'(s_out_valid), 32'd1);
        check_word("lw_op_code", 32'(s_op_code), 32'h23);
        check_word("lw_rs", 32'(s_rs), 32'd9);
        check_word("lw_rt", 32'(s_rt), 32'd10);
        check_word("lw_imm_sext", s_imm_sext, 32'h0000_0004);
        check_word("lw_out_pc", s_out_pc, 32'h0000_3000);

        apply_stimulus(1'b1, 32'h2108_FFFF, 32'h0000_3004, 1'b1, 1'b0);
        next_cycle();
        check_word("addi_imm_sext", s_imm_sext, 32'hFFFF_FFFF);
        check_word("addi_imm_zext", s_imm_zext, 32'h0000_FFFF);
        check_word("addi_imm_lui", s_imm_lui, 32'hFFFF_0000);

        apply_stimulus(1'b1, 32'h012A_4020, 32'h0000_3008, 1'b1, 1'b0);
        next_cycle();
        check_word("add_is_rtype", 32'(s_is_rtype), 32'd1);
        check_word("add_rd", 32'(s_rd), 32'd8);
        check_word("add_func", 32'(s_func), 32'h20);

        apply_stimulus(1'b1, 32'h0810_0004, 32'h0000_3000, 1'b1, 1'b0);
        next_cycle();
        check_word("j_target", s_jump_target, 32'h0040_0010);

        apply_stimulus(1'b1, 32'h0810_0004, 32'hFFFF_FFFC, 1'b1, 1'b0);
        next_cycle();
        check_word("j_target_wrap", s_jump_target, 32'h0040_0010);

        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        check_word("drain_out_valid", 32'(s_out_valid), 32'd0);

        // Backpressure: A, B, C back to back with out_ready low
        apply_stimulus(1'b1, 32'h8C43_0010, 32'h0000_4000, 1'b0, 1'b0);
        next_cycle();
        check_word("bp_a_valid", 32'(s_out_valid), 32'd1);
        check_word("bp_a_in_ready", 32'(s_in_ready), 32'd1);
        apply_stimulus(1'b1, 32'h0085_2020, 32'h0000_4004, 1'b0, 1'b0);
        next_cycle();
        check_word("bp_b_in_ready", 32'(s_in_ready), 32'd0);
        check_word("bp_b_head", s_out_pc, 32'h0000_4000);
        apply_stimulus(1'b1, 32'h3C05_ABCD, 32'h0000_4008, 1'b0, 1'b0);
        next_cycle();
        check_word("bp_c_in_ready", 32'(s_in_ready), 32'd0);
        check_word("bp_c_head", s_out_pc, 32'h0000_4000);
        apply_stimulus(1'b1, 32'h3C05_ABCD, 32'h0000_4008, 1'b1, 1'b0);
        next_cycle();
        check_word("bp_rel_b_valid", 32'(s_out_valid), 32'd1);
        check_word("bp_rel_b_head", s_out_pc, 32'h0000_4004);
        check_word("bp_rel_in_ready", 32'(s_in_ready), 32'd1);
        next_cycle();
        check_word("bp_rel_c_valid", 32'(s_out_valid), 32'd1);
        check_word("bp_rel_c_head", s_out_pc, 32'h0000_4008);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        check_word("bp_empty", 32'(s_out_valid), 32'd0);

        // Flush with both entries full, input offered and head consumed
        apply_stimulus(1'b1, 32'h24A5_0001, 32'h0000_5000, 1'b0, 1'b0);
        next_cycle();
        apply_stimulus(1'b1, 32'h10A0_FFFE, 32'h0000_5004, 1'b0, 1'b0);
        next_cycle();
        check_word("fl_full_in_ready", 32'(s_in_ready), 32'd0);
        apply_stimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_5008, 1'b1, 1'b1);
        next_cycle();
        check_word("fl_out_valid", 32'(s_out_valid), 32'd0);
        check_word("fl_in_ready", 32'(s_in_ready), 32'd1);
        apply_stimulus(1'b1, 32'h3406_0F0F, 32'h0000_500C, 1'b0, 1'b1);
        next_cycle();
        check_word("fl_drop_input", 32'(s_out_valid), 32'd0);
        apply_stimulus(1'b1, 32'h0C00_0123, 32'h0000_6000, 1'b1, 1'b0);
        next_cycle();
        check_word("fl_next_valid", 32'(s_out_valid), 32'd1);
        check_word("fl_next_pc", s_out_pc, 32'h0000_6000);
        check_word("fl_next_op", 32'(s_op_code), 32'h03);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        next_cycle();

        // Asynchronous reset with both entries held
        apply_stimulus(1'b1, 32'hAC62_0008, 32'h0000_7000, 1'b0, 1'b0);
        next_cycle();
        apply_stimulus(1'b1, 32'h03E0_0008, 32'h0000_7004, 1'b0, 1'b0);
        next_cycle();
        check_word("ar_full_in_ready", 32'(s_in_ready), 32'd0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check_word("ar_out_valid", 32'(s_out_valid), 32'd0);
        check_word("ar_in_ready", 32'(s_in_ready), 32'd1);
        check_word("ar_out_pc", s_out_pc, 32'h0000_0000);
        #4 rstn = 1'b1;
        next_cycle();
        apply_stimulus(1'b1, 32'h2402_000A, 32'h0000_8000, 1'b1, 1'b0);
        next_cycle();
        check_word("ar_push_valid", 32'(s_out_valid), 32'd1);
        check_word("ar_push_pc", s_out_pc, 32'h0000_8000);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        next_cycle();

        // Single-entry instance: in_ready follows out_ready combinationally
        apply_flow(1'b1, 32'h8C43_0010, 32'h0000_9000, 1'b0, 1'b0);
        #1;
        check_word("sf_empty_in_ready", 32'(f_in_ready), 32'd1);
        next_cycle();
        check_word("sf_a_valid", 32'(f_out_valid), 32'd1);
        check_word("sf_full_in_ready", 32'(f_in_ready), 32'd0);
        apply_flow(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        check_word("sf_comb_in_ready", 32'(f_in_ready), 32'd1);
        apply_flow(1'b1, 32'h0085_2020, 32'h0000_9004, 1'b1, 1'b0);
        next_cycle();
        check_word("sf_b_head", f_out_pc, 32'h0000_9004);
        apply_flow(1'b1, 32'h3C05_ABCD, 32'h0000_9008, 1'b1, 1'b0);
        next_cycle();
        check_word("sf_c_head", f_out_pc, 32'h0000_9008);
        apply_flow(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check_word("sf_stall_in_ready", 32'(f_in_ready), 32'd0);
        apply_flow(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        check_word("sf_release_in_ready", 32'(f_in_ready), 32'd1);
        next_cycle();
        check_word("sf_empty", 32'(f_out_valid), 32'd0);

        next_cycle();
        check_word("skid_queue_empty", 32'(s_q.size()), 32'd0);
        check_word("flow_queue_empty", 32'(f_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decd_stage.md
# decd_stage

Registered instruction-decode stage: accepts a 32-bit MIPS instruction and its PC over a valid/ready handshake and holds it in an elastic buffer. Presents the split fields, extended immediates and jump target to the ID stage. Sits between instruction fetch and register read, replacing the purely combinational field splitter. Supports stall via backpressure and a synchronous flush for branch/jump redirects.

## Interface
Parameters:
- XLEN, 32: width of extended immediates; must be ≥ 32.
- PC_W, 32: PC width; must be ≥ 32.
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  PC of the instruction.
- flush  in  1  discard all held and incoming entries.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  consumer takes the entry.
- out_pc  out  PC_W  PC of the head entry.
- op_code  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- func  out  6  instr[5:0].
- imm16  out  16  instr[15:0].
- imm26  out  26  instr[25:0].
- imm_sext  out  XLEN  imm16 sign-extended.
- imm_zext  out  XLEN  imm16 zero-extended.
- imm_lui  out  XLEN  {imm16, 16'b0}, zero-extended to XLEN.
- jump_target  out  PC_W  {(out_pc+4)[PC_W-1:28], imm26, 2'b00}.
- is_rtype  out  1  op_code == 0.

## Operation
- Storage: main entry (head) plus, when SKID=1, a skid entry. Each entry holds instr, pc and a valid bit.
- All outputs are combinational decodes of the main entry. With out_valid=0, they decode the held contents, which are don't-care to consumers.
- Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
- SKID=1:
  - in_ready = ~skid_valid. It is driven only from a register.
  - Push with main empty, or with main popping in the same cycle: the input goes to main.
  - Push with main full and not popping: the input goes to skid.
  - Pop with skid full: skid moves to main and skid empties.
- SKID=0:
  - in_ready = ~main_valid | out_ready.
  - Push loads main; pop without push empties main.
- Flush: both valid bits clear at the next edge. Flush has priority over a simultaneous push (the input is dropped) and over a simultaneous pop (the pop still counts as consumed this cycle).
- Arithmetic: pc+4 is computed mod 2^PC_W. Sign extension replicates imm16[15] into bits XLEN-1..16.

## Timing
- Reset (rstn low, asynchronous):
  - valid bits clear; stored instr and pc reset to 0.
  - out_valid=0; all decode outputs reflect instr 0x00000000 (is_rtype=1), out_pc=0, jump_target=0x00000000.
  - in_ready=1.
- Latency: push at edge N gives out_valid=1 with fields valid after edge N. There is no combinational in→out path.
- Throughput: 1 instruction per cycle while out_ready=1.
- SKID=1 full case: after out_ready drops, at most one further instruction is accepted. in_ready falls the cycle after the skid fills and rises the cycle after the skid drains.
- Reset mid-transfer drops all entries. The first legal push is at the first edge with rstn high.
- Instruction order is preserved; no entry is duplicated or lost except by flush or reset.

## Test plan
- Reset, then push 0x8D2A0004 with pc 0x00003000 and out_ready=1 → next cycle: op_code=0x23, rs=9, rt=10, imm_sext=0x00000004, out_pc=0x00003000.
- Push 0x2108FFFF → imm_sext=0xFFFFFFFF, imm_zext=0x0000FFFF, imm_lui=0xFFFF0000. Push 0x012A4020 → is_rtype=1, rd=8, func=0x20.
- Push 0x08100004 with pc 0x00003000 → jump_target=0x00400010. With pc 0xFFFFFFFC (PC_W=32), pc+4 wraps to 0, so jump_target=0x00400010.
- SKID=1: hold out_ready=0 and push A, B, C back-to-back → A and B accepted, in_ready=0 while C is held. Raise out_ready → outputs in order A, B, C with no gap, and in_ready=1 one cycle after the skid drains.
- Flush asserted with both entries full and in_valid=1 in the same cycle → out_valid=0 next cycle and the input is not captured. The next push appears normally.
- Assert rstn low asynchronously mid-stream with entries held → out_valid drops before the next edge and in_ready=1. Repeat the ordering scenario with SKID=0 and confirm in_ready follows out_ready combinationally.
